// File: rtl/nn_param_update_bank_pkg.sv
// rtl/nn_param_update_bank_pkg.sv - shared encodings for the parameter update bank
// Purpose: update-mode and sign encodings used by the bank and its adder.
// Ports: none (package).
package nn_param_update_bank_pkg;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_ACCUM = 1'b1;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

endpackage

// File: rtl/nn_sm_sat_add.sv
// rtl/nn_sm_sat_add.sv - combinational sign-magnitude saturating adder
// Purpose: adds two sign-magnitude operands, clamping the magnitude to all-ones on overflow.
// Ports: a_mag/a_sign (current value), b_mag/b_sign (modifier) in;
//        mag/sign (result), sat (overflow clamped) out.
module nn_sm_sat_add
    import nn_param_update_bank_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a_mag,
    input  logic         a_sign,
    input  logic [N-1:0] b_mag,
    input  logic         b_sign,
    output logic [N-1:0] mag,
    output logic         sign,
    output logic         sat
);

    logic [N:0] sum;

    always_comb begin
        sum  = {1'b0, a_mag} + {1'b0, b_mag};
        mag  = '0;
        sign = SIGN_POS;
        sat  = 1'b0;
        if (a_sign == b_sign) begin
            sign = a_sign;
            if (sum[N]) begin
                mag = '1;
                sat = 1'b1;
            end else begin
                mag = sum[N-1:0];
            end
        end else if (b_mag > a_mag) begin
            mag  = b_mag - a_mag;
            sign = b_sign;
        end else begin
            mag  = a_mag - b_mag;
            sign = a_sign;
        end
        // Keep a single encoding for zero so downstream never sees "-0".
        if (mag == '0) begin
            sign = SIGN_POS;
        end
    end

endmodule

// File: rtl/nn_param_update_bank.sv
// rtl/nn_param_update_bank.sv - bank of sign-magnitude parameters with gated LOAD/ACCUM updates
// Purpose: holds NCH parameters (magnitude, sign, resistance) updated via one shared
//          two-stage request port; ACCUM applies once every resistance+1 requests.
// Ports: CLK, INIT (sync active-high); EN, UPD_VALID/UPD_READY, UPD_CH, UPD_MODE,
//        MODIFIER, SIGN_MODIFIER, RESISTANCE_NEW request; INITIAL_* reset values;
//        OUT, SIGN_OUT, RESISTANCE_OUT state; UPD_DONE/UPD_APPLIED retire pulse; SAT_FLAG.
module nn_param_update_bank
    import nn_param_update_bank_pkg::*;
#(
    parameter int  N            = 8,
    parameter int  N_RESISTANCE = 8,
    parameter int  NCH          = 4,
    localparam int CH_W         = $clog2(NCH)
) (
    input  logic                      CLK,
    input  logic                      INIT,
    input  logic                      EN,
    input  logic                      UPD_VALID,
    output logic                      UPD_READY,
    input  logic [CH_W-1:0]           UPD_CH,
    input  logic                      UPD_MODE,
    input  logic [N-1:0]              MODIFIER,
    input  logic                      SIGN_MODIFIER,
    input  logic [N_RESISTANCE-1:0]   RESISTANCE_NEW,
    input  logic [NCH*N-1:0]          INITIAL_VALUE,
    input  logic [NCH-1:0]            INITIAL_SIGN,
    input  logic [NCH*N_RESISTANCE-1:0] INITIAL_RESISTANCE,
    output logic [NCH*N-1:0]          OUT,
    output logic [NCH-1:0]            SIGN_OUT,
    output logic [NCH*N_RESISTANCE-1:0] RESISTANCE_OUT,
    output logic                      UPD_DONE,
    output logic                      UPD_APPLIED,
    output logic [NCH-1:0]            SAT_FLAG
);

    logic [N-1:0]            val_q [NCH];
    logic [N_RESISTANCE-1:0] res_q [NCH];
    logic [N_RESISTANCE-1:0] cnt_q [NCH];
    logic [NCH-1:0]          sgn_q;
    logic [NCH-1:0]          sat_q;
    logic                    done_q;
    logic                    applied_q;

    // Stage-1 request register.
    logic                    s1_valid;
    logic [CH_W-1:0]         s1_ch;
    logic                    s1_mode;
    logic [N-1:0]            s1_mod;
    logic                    s1_sign;
    logic [N_RESISTANCE-1:0] s1_res;

    logic [N-1:0]            add_mag;
    logic                    add_sign;
    logic                    add_sat;

    logic [N-1:0]            nxt_val;
    logic                    nxt_sign;
    logic [N_RESISTANCE-1:0] nxt_res;
    logic [N_RESISTANCE-1:0] nxt_cnt;
    logic                    nxt_applied;
    logic                    nxt_sat;

    assign UPD_READY = EN & ~INIT;

    nn_sm_sat_add #(.N(N)) u_add (
        .a_mag  (val_q[s1_ch]),
        .a_sign (sgn_q[s1_ch]),
        .b_mag  (s1_mod),
        .b_sign (s1_sign),
        .mag    (add_mag),
        .sign   (add_sign),
        .sat    (add_sat)
    );

    // Stage 1 reads the registered state directly; a write from the previous
    // request has already landed, so same-channel streaming needs no bypass.
    always_comb begin
        nxt_val     = val_q[s1_ch];
        nxt_sign    = sgn_q[s1_ch];
        nxt_res     = res_q[s1_ch];
        nxt_cnt     = cnt_q[s1_ch];
        nxt_applied = 1'b0;
        nxt_sat     = 1'b0;
        if (s1_mode == MODE_LOAD) begin
            nxt_val     = s1_mod;
            nxt_sign    = s1_sign;
            nxt_res     = s1_res;
            nxt_cnt     = s1_res;
            nxt_applied = 1'b1;
        end else if (cnt_q[s1_ch] != '0) begin
            nxt_cnt = cnt_q[s1_ch] - N_RESISTANCE'(1);
        end else begin
            nxt_val     = add_mag;
            nxt_sign    = add_sign;
            nxt_cnt     = res_q[s1_ch];
            nxt_applied = 1'b1;
            nxt_sat     = add_sat;
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= INITIAL_VALUE[i*N +: N];
                res_q[i] <= INITIAL_RESISTANCE[i*N_RESISTANCE +: N_RESISTANCE];
                cnt_q[i] <= INITIAL_RESISTANCE[i*N_RESISTANCE +: N_RESISTANCE];
            end
            sgn_q     <= INITIAL_SIGN;
            sat_q     <= '0;
            s1_valid  <= 1'b0;
            done_q    <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            s1_valid <= UPD_VALID & EN;
            if (UPD_VALID & EN) begin
                s1_ch   <= UPD_CH;
                s1_mode <= UPD_MODE;
                s1_mod  <= MODIFIER;
                s1_sign <= SIGN_MODIFIER;
                s1_res  <= RESISTANCE_NEW;
            end
            done_q    <= s1_valid;
            applied_q <= s1_valid & nxt_applied;
            if (s1_valid) begin
                val_q[s1_ch] <= nxt_val;
                sgn_q[s1_ch] <= nxt_sign;
                res_q[s1_ch] <= nxt_res;
                cnt_q[s1_ch] <= nxt_cnt;
                if (nxt_sat) begin
                    sat_q[s1_ch] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign OUT[g*N +: N]                            = val_q[g];
        assign RESISTANCE_OUT[g*N_RESISTANCE +: N_RESISTANCE] = res_q[g];
    end

    assign SIGN_OUT    = sgn_q;
    assign SAT_FLAG    = sat_q;
    assign UPD_DONE    = done_q;
    assign UPD_APPLIED = applied_q;

endmodule
